// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory answering the pipeline's MEM-stage data port.
//   Serves word reads, word writes and the read + write pair used for
//   byte/halfword stores. WAIT_STATES extra cycles stretch every access;
//   `ready` marks the cycle in which an access completes.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles per access, 0..15 (0 = combinational pass-through)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset (array contents untouched)
//   adr[31:0]  in   byte address; word index is adr[31:2]
//   data_in    in   write data
//   mem_read   in   read request
//   mem_write  in   write request (wins when both are high; old word is returned)
//   data_out   out  read data, zero unless a read completes this cycle
//   ready      out  access completes this cycle
//   err        out  completing access targeted a word index >= DEPTH
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem [DEPTH];

  logic [29:0]   w_idx;
  logic          w_oor;
  logic          w_unused_adr_lo;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;

  assign w_idx = adr[31:2];
  assign w_oor = ({2'b00, w_idx} >= 32'(DEPTH));
  // Byte-lane bits carry no meaning for a word-organised array.
  assign w_unused_adr_lo = ^adr[1:0];

  // Single write port; each mode below decides when it fires.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  if (WAIT_STATES == 0) begin : g_pass
    logic w_req;

    // Reset only masks the handshake; the array itself is never cleared.
    assign w_req    = rst & (mem_read | mem_write);
    assign ready    = w_req;
    assign err      = w_req & w_oor;
    assign data_out = (rst & mem_read & ~w_oor) ? r_mem[w_idx[AW-1:0]] : '0;

    assign w_we     = rst & mem_write & ~w_oor;
    assign w_waddr  = w_idx[AW-1:0];
    assign w_wdata  = data_in;
  end else begin : g_fsm
    typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_oor;
    logic          r_rd;
    logic          r_wr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata_q;
    logic          r_ready;
    logic          r_err;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_addr    <= '0;
        r_oor     <= 1'b0;
        r_rd      <= 1'b0;
        r_wr      <= 1'b0;
        r_wdata   <= '0;
        r_rdata_q <= '0;
        r_ready   <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (mem_read | mem_write) begin
              r_addr  <= w_idx[AW-1:0];
              r_oor   <= w_oor;
              r_rd    <= mem_read;
              r_wr    <= mem_write;
              r_wdata <= data_in;
              r_cnt   <= 4'(WAIT_STATES - 1);
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (r_cnt == '0) begin
              // rdata_q doubles as the registered data_out: it only holds a
              // non-zero word during DONE of an in-range read.
              r_rdata_q <= (r_rd & ~r_oor) ? r_mem[r_addr] : '0;
              r_ready   <= 1'b1;
              r_err     <= r_oor;
              r_state   <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_DONE: begin
            r_rdata_q <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end

    assign data_out = r_rdata_q;
    assign ready    = r_ready;
    assign err      = r_err;

    // Latched write lands on the edge that ends DONE; an asynchronous reset
    // forces IDLE first, so an interrupted write never reaches the array.
    assign w_we     = (r_state == S_DONE) & r_wr & ~r_oor;
    assign w_waddr  = r_addr;
    assign w_wdata  = r_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Two responders side by side: a pass-through instance (WAIT_STATES=0) and
//   a wait-state instance (WAIT_STATES=3), both DEPTH=1024. Directed cases
//   plus randomized traffic are checked against an associative-array model
//   of the memory and a fixed per-access timing expectation.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_0, rd_0, wr_0, ready_0, err_0;
  logic [31:0] adr_0, din_0, dout_0;
  logic        rst_w, rd_w, wr_w, ready_w, err_w;
  logic [31:0] adr_w, din_w, dout_w;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_0 (
    .clk(clk), .rst(rst_0), .adr(adr_0), .data_in(din_0),
    .mem_read(rd_0), .mem_write(wr_0),
    .data_out(dout_0), .ready(ready_0), .err(err_0)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut_w (
    .clk(clk), .rst(rst_w), .adr(adr_w), .data_in(din_w),
    .mem_read(rd_w), .mem_write(wr_w),
    .data_out(dout_w), .ready(ready_w), .err(err_w)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference memories, keyed by word index.
  logic [31:0] m0 [int unsigned];
  logic [31:0] mw [int unsigned];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    return ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] pick_adr();
    logic [29:0] w;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      w = 30'($urandom_range(DEPTH, 32'h3FFF_FFFF));
    else if (r == 1) w = 30'(DEPTH - 1);
    else             w = 30'($urandom_range(0, 31));
    return {w, 2'($urandom_range(0, 3))};
  endfunction

  // Pass-through access: everything resolves inside the cycle.
  task automatic access0(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic        oor;
    logic [31:0] xd;
    oor = is_oor(a);
    xd  = (rd && !oor) ? m0[int'(a[31:2])] : '0;
    @(negedge clk);
    rd_0 = rd; wr_0 = wr; adr_0 = a; din_0 = d;
    #1;
    check("p_ready", 32'(ready_0), 32'(rd | wr));
    check("p_dout",  dout_0, xd);
    check("p_err",   32'(err_0), 32'((rd | wr) & oor));
    @(posedge clk);
    #1;
    rd_0 = 1'b0; wr_0 = 1'b0;
    if (wr && !oor) m0[int'(a[31:2])] = d;
  endtask

  // Wait-state access: ready must stay low for WS cycles after the sampling
  // cycle, then pulse for one cycle with the expected data and err.
  task automatic accessw(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit jitter);
    logic        oor;
    logic [31:0] xd;
    oor = is_oor(a);
    xd  = (rd && !oor) ? mw[int'(a[31:2])] : '0;
    @(negedge clk);
    check("w_idle_ready", 32'(ready_w), 32'd0);
    check("w_idle_dout",  dout_w, 32'd0);
    rd_w = rd; wr_w = wr; adr_w = a; din_w = d;
    for (int k = 1; k <= int'(WS) + 1; k++) begin
      @(negedge clk);
      if (k <= int'(WS)) begin
        check("w_wait_ready", 32'(ready_w), 32'd0);
        check("w_wait_dout",  dout_w, 32'd0);
        check("w_wait_err",   32'(err_w), 32'd0);
        if (jitter) begin
          rd_w = 1'($urandom); wr_w = 1'($urandom);
          adr_w = $urandom; din_w = $urandom;
        end else begin
          rd_w = 1'b0; wr_w = 1'b0;
        end
      end else begin
        check("w_done_ready", 32'(ready_w), 32'd1);
        check("w_done_dout",  dout_w, xd);
        check("w_done_err",   32'(err_w), 32'(oor));
        rd_w = 1'b0; wr_w = 1'b0;
      end
    end
    if (wr && !oor) mw[int'(a[31:2])] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic        rd, wr;

    rst_0 = 1'b0; rd_0 = 1'b0; wr_0 = 1'b0; adr_0 = '0; din_0 = '0;
    rst_w = 1'b0; rd_w = 1'b0; wr_w = 1'b0; adr_w = '0; din_w = '0;
    repeat (2) @(negedge clk);
    check("rst_ready_0", 32'(ready_0), 32'd0);
    check("rst_dout_0",  dout_0, 32'd0);
    check("rst_err_0",   32'(err_0), 32'd0);
    check("rst_ready_w", 32'(ready_w), 32'd0);
    check("rst_dout_w",  dout_w, 32'd0);
    check("rst_err_w",   32'(err_w), 32'd0);
    rst_0 = 1'b1; rst_w = 1'b1;

    // Give every word in the address pool a known value.
    for (int unsigned i = 0; i <= 32; i++) begin
      a = (i == 32) ? 32'((DEPTH - 1) * 4) : 32'(i * 4);
      access0(1'b0, 1'b1, a, $urandom);
      accessw(1'b0, 1'b1, a, $urandom, 1'b0);
    end

    // Pass-through write then read-back.
    access0(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access0(1'b1, 1'b0, 32'h10, 32'h0);
    check("p_rb_const", dout_0, 32'hDEAD_BEEF);
    access0(1'b0, 1'b1, 32'h1000, 32'hBAD0_BAD0);
    access0(1'b1, 1'b0, 32'h1000, 32'h0);
    access0(1'b1, 1'b0, 32'h0, 32'h0);
    access0(1'b1, 1'b1, 32'h50, 32'h2);
    access0(1'b1, 1'b0, 32'h50, 32'h0);

    // Wait-state read of a preloaded word.
    accessw(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    accessw(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Byte-store read-modify-write.
    accessw(1'b0, 1'b1, 32'h40, 32'h1122_3344, 1'b0);
    accessw(1'b1, 1'b0, 32'h41, 32'h0, 1'b0);
    accessw(1'b0, 1'b1, 32'h41, 32'h1122_AB44, 1'b0);
    accessw(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    // Out-of-range write must not alias onto index 0.
    accessw(1'b0, 1'b1, 32'h1000, 32'hBAD0_BAD0, 1'b0);
    accessw(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
    accessw(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Simultaneous read+write returns the old word.
    accessw(1'b0, 1'b1, 32'h50, 32'h1, 1'b0);
    accessw(1'b1, 1'b1, 32'h50, 32'h2, 1'b0);
    accessw(1'b1, 1'b0, 32'h50, 32'h0, 1'b0);

    // Reset during the second WAIT cycle discards the write.
    @(negedge clk);
    rd_w = 1'b0; wr_w = 1'b1; adr_w = 32'h30; din_w = 32'hCAFE_F00D;
    @(negedge clk);
    rd_w = 1'b0; wr_w = 1'b0;
    @(negedge clk);
    rst_w = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready_w), 32'd0);
    check("mid_rst_dout",  dout_w, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_hold_ready", 32'(ready_w), 32'd0);
      check("mid_rst_hold_err",   32'(err_w), 32'd0);
    end
    rst_w = 1'b1;
    accessw(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    // Randomized traffic, with input churn during WAIT on the stalled port.
    for (int i = 0; i < 150; i++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = pick_adr(); d = $urandom;
      access0(rd, wr, a, d);
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = pick_adr(); d = $urandom;
      accessw(rd, wr, a, d, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that serves as the responder for the pipeline's MEM-stage data port. It answers word reads, word writes, and the two-step read-modify-write sequence the pipeline issues for byte and halfword stores. A programmable number of wait states stretches every access. A `ready` handshake tells the hazard logic when to hold the pipeline enables.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words. Must be a power of two, at least 2.
- `WAIT_STATES`, 0: extra cycles inserted per access, 0..15.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `adr`  in  32  byte address from the pipeline. Bits [1:0] are ignored; word index is `adr[31:2]`.
- `data_in`  in  32  write data; the merged word for byte/halfword stores.
- `mem_read`  in  1  read request (word read, or step 1 of a read-modify-write).
- `mem_write`  in  1  write request.
- `data_out`  out  32  read data returned to the pipeline.
- `ready`  out  1  access completes this cycle; the pipeline may advance.
- `err`  out  1  the completing access targeted a word index of `DEPTH` or more.

## Operation
- Request: `req = mem_read | mem_write`. When both are high, the access is a write.
  - A write with both high commits `data_in`.
  - `data_out` returns the pre-write word.
- Out-of-range access (`adr[31:2] >= DEPTH`):
  - write is dropped;
  - `data_out` = 0;
  - `err` = 1 in the completing cycle.
- `data_out` = 0 in every cycle where `ready` is 0 or no read completes.
- Array contents are not affected by `rst`.
- `WAIT_STATES == 0`, pass-through mode, no FSM:
  - `ready = req`, combinational;
  - read data is the combinational array word at `adr`;
  - the write commits at the rising edge ending the cycle.
- `WAIT_STATES > 0`, FSM with states IDLE, WAIT, DONE:
  - IDLE: `ready` = 0. On `req`, latch `adr`, `data_in` and op into request registers; counter ← `WAIT_STATES-1`; go to WAIT.
  - WAIT: `ready` = 0. Decrement the counter each cycle. When the counter is 0, register the read word from the latched address into `rdata_q`, then go to DONE.
  - DONE: `ready` = 1 for exactly one cycle. `data_out` = `rdata_q` when the latched op was a read. A latched write commits at the edge ending DONE. Return to IDLE.
  - Inputs are sampled only on the IDLE→WAIT transition. Changes during WAIT/DONE are ignored.
  - `req` still high in the cycle after DONE is a new access.
- Read-modify-write (byte/halfword store): the pipeline issues a read, captures `data_out` on `ready`, then issues a write of the merged word to the same address. These are two independent accesses. No special handling is required beyond the read returning the committed contents.
- Read-after-write to the same word in consecutive accesses returns the newly written data. The write has committed before the next access samples the array.

## Timing
- Reset values (asynchronous, `rst` low):
  - state = IDLE;
  - counter = 0;
  - `rdata_q` = 0;
  - latched request = 0;
  - `ready` = 0 (W>0);
  - `err` = 0 (W>0);
  - `data_out` = 0.
- Access latency from `req` first seen in IDLE to the `ready` cycle:
  - `WAIT_STATES+1` cycles when W>0;
  - 0 cycles when W=0.
- Throughput with W>0: one access per `WAIT_STATES+2` cycles, including the IDLE sampling cycle.
- Reset asserted mid-access:
  - the FSM returns to IDLE immediately;
  - a pending latched write is discarded and the array is unchanged;
  - no `ready` pulse is produced.
- `req` deasserted during WAIT: the access still completes. `ready` still pulses and a latched write still commits.
- Counter width is 4 bits, with no wrap: it stops at 0.

## Test plan
- W=0:
  - write `adr`=0x10, `data_in`=0xDEADBEEF;
  - next cycle read 0x10 → `ready`=1 in the same cycle, `data_out`=0xDEADBEEF, `err`=0.
- W=3:
  - read of 0x20 (preloaded 0x12345678) → `ready` low 3 cycles, then high for 1 cycle with `data_out`=0x12345678;
  - `data_out`=0 in all other cycles.
- W=2, byte-store RMW at 0x41:
  - read returns 0x11223344;
  - write of 0x1122AB44 to 0x41;
  - read 0x40 → 0x1122AB44.
- `DEPTH`=1024, W=1:
  - write to 0x00001000 (index 1024) → `err`=1 with `ready`, array unchanged;
  - read 0x00001000 → `data_out`=0, `err`=1.
- W=4:
  - write 0xCAFEF00D to 0x30;
  - assert `rst` low in the 2nd WAIT cycle;
  - after release, read 0x30 → previous contents; no `ready` pulse during reset.
- W=2, `mem_read`=`mem_write`=1 at 0x50 (old 0x1, `data_in`=0x2) → `data_out`=0x1 at `ready`; a subsequent read returns 0x2.
